// File: rtl/switch_debouncer.sv
// Debounces one raw switch/button input: two-flop synchronizer, stability counter
// and a four-state FSM producing a clean level plus one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 19
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             sync0;
  logic             sync1;
  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  // Synchronizer, FSM state/counter, and outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      state      <= S_LOW;
      cnt        <= CNT_ZERO;
      clean_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync0      <= noisy_in;
      sync1      <= sync0;
      state      <= stateNext;
      cnt        <= cntNext;
      clean_out  <= (stateNext == S_HIGH) || (stateNext == S_WAIT_LOW);
      rise_pulse <= (state == S_WAIT_HIGH) && (stateNext == S_HIGH);
      fall_pulse <= (state == S_WAIT_LOW) && (stateNext == S_LOW);
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = CNT_ZERO;
    case (state)
      S_LOW: begin
        if (sync1) begin
          stateNext = S_WAIT_HIGH;
          cntNext   = CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync1) begin
          stateNext = S_LOW;
        end else if (cnt == CNT_LAST) begin
          stateNext = S_HIGH;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync1) begin
          stateNext = S_WAIT_LOW;
          cntNext   = CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (sync1) begin
          stateNext = S_HIGH;
        end else if (cnt == CNT_LAST) begin
          stateNext = S_LOW;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end
      default: begin
        stateNext = S_LOW;
      end
    endcase
  end

endmodule
